regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 27 ++
 rtl/regfile_wb_arbiter_if.sv | 29 ++
 rtl/regfile_wb_arbiter_rr_pick.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter and
// the register file itself.
package regfile_wb_arbiter_pkg;

   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int AW   = 5;

   localparam int REQ_ALU    = 0;
   localparam int REQ_LOAD   = 1;
   localparam int REQ_MULDIV = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Round-robin successor: the requester after idx, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, the arbiter and the register file
// write port.
interface regfile_wb_arbiter_if #(
   parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
   parameter int DW   = regfile_wb_arbiter_pkg::DW,
   parameter int AW   = regfile_wb_arbiter_pkg::AW
);

   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    reqLast;
   logic [NREQ*AW-1:0] reqAddr;
   logic [NREQ*DW-1:0] reqData;
   logic [NREQ-1:0]    gnt;
   logic [AW-1:0]      wr;
   logic [DW-1:0]      writeData;
   logic               writeEN;
   logic               locked;

   modport master (
      output req, reqLast, reqAddr, reqData,
      input  gnt, wr, writeData, writeEN, locked
   );

   modport slave (
      input  req, reqLast, reqAddr, reqData,
      output gnt, wr, writeData, writeEN, locked
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Returns one-hot grant, binary index and a found flag.
module regfile_wb_arbiter_rr_pick #(
   parameter int N  = regfile_wb_arbiter_pkg::NREQ,
   parameter int PW = regfile_wb_arbiter_pkg::ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            gnt[j] = 1'b1;
            idx    = PW'(j);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with burst locking for the single register
// file write port; write port outputs are registered.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | round-robin search from ptr; a non-last beat locks to winner
//   ST_LOCKED | only owner may be granted; its last beat releases the lock
module regfile_wb_arbiter #(
   parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
   parameter int DW   = regfile_wb_arbiter_pkg::DW,
   parameter int AW   = regfile_wb_arbiter_pkg::AW
) (
   input  logic                 Clk,
   input  logic                 Reset,
   regfile_wb_arbiter_if.slave  bus
);

   import regfile_wb_arbiter_pkg::*;

   localparam int PW = ptr_width(NREQ);

   arb_state_t      state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;

   logic [NREQ-1:0] pick_gnt;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;

   logic [NREQ-1:0] gnt_c;
   logic            accept;
   logic [PW-1:0]   win;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;
   logic            win_last;

   logic [AW-1:0]   wr_q;
   logic [DW-1:0]   write_data_q;
   logic            write_en_q;

   regfile_wb_arbiter_rr_pick #(
      .N  (NREQ),
      .PW (PW)
   ) u_rr_pick (
      .req (bus.req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Grant depends only on req, state, ptr and owner; payload is muxed after.
   always_comb begin
      gnt_c  = '0;
      accept = 1'b0;
      win    = owner;
      if (!Reset) begin
         case (state)
            ST_IDLE: begin
               gnt_c  = pick_gnt;
               accept = pick_any;
               win    = pick_idx;
            end
            ST_LOCKED: begin
               accept       = bus.req[owner];
               gnt_c[owner] = bus.req[owner];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      win_addr = '0;
      win_data = '0;
      win_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_c[i]) begin
            win_addr = win_addr | bus.reqAddr[i*AW +: AW];
            win_data = win_data | bus.reqData[i*DW +: DW];
            win_last = win_last | bus.reqLast[i];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         owner        <= '0;
         wr_q         <= '0;
         write_data_q <= '0;
         write_en_q   <= 1'b0;
      end else begin
         write_en_q <= 1'b0;
         if (accept) begin
            wr_q         <= win_addr;
            write_data_q <= win_data;
            // Register 0 is hardwired: the beat is consumed but never written.
            write_en_q   <= (win_addr != '0);
            if (win_last) begin
               ptr   <= PW'(rr_next(int'(win), NREQ));
               state <= ST_IDLE;
            end else begin
               owner <= win;
               state <= ST_LOCKED;
            end
         end
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.wr        = wr_q;
   assign bus.writeData = write_data_q;
   assign bus.writeEN   = write_en_q;
   assign bus.locked    = (state == ST_LOCKED);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a negedge-capturing register
// file model behind the write port.
module tb_regfile_wb_arbiter;

   logic Clk;
   logic Reset;
   int   n_vec;
   int   n_miss;

   regfile_wb_arbiter_if #(.NREQ(3), .DW(32), .AW(5)) bus ();

   regfile_wb_arbiter #(.NREQ(3), .DW(32), .AW(5)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   logic [31:0] rf [32];

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
   end

   always @(negedge Clk) begin
      if (bus.writeEN === 1'b1) rf[bus.wr] = bus.writeData;
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input int i, input logic r, input logic last,
                        input logic [4:0] a, input logic [31:0] d);
      bus.req[i]             = r;
      bus.reqLast[i]         = last;
      bus.reqAddr[i*5 +: 5]  = a;
      bus.reqData[i*32 +: 32] = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b1, 5'd0, 32'h0);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic reset_dut();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d, input logic en);
      chk({tag, ".wr"},        32'(bus.wr), 32'(a));
      chk({tag, ".writeData"}, bus.writeData, d);
      chk({tag, ".writeEN"},   32'(bus.writeEN), 32'(en));
   endtask

   int          seq [4];
   logic [31:0] rr_data [3];

   initial begin
      n_vec  = 0;
      n_miss = 0;
      seq    = '{0, 1, 2, 0};
      rr_data = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};

      // Reset with all requests raised: no grant allowed, outputs cleared.
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) drive(i, 1'b1, 1'b1, 5'(i + 1), 32'hABCD_0000);
      #2;
      chk("rst.gnt", 32'(bus.gnt), 32'h0);
      step();
      chk_wr("rst", 5'd0, 32'h0, 1'b0);
      chk("rst.locked", 32'(bus.locked), 32'h0);
      clear_all();
      step();
      Reset = 1'b0;

      // Single ALU write of -344 to r3.
      drive(0, 1'b1, 1'b1, 5'd3, 32'hFFFF_FEA8);
      #1;
      chk("single.gnt", 32'(bus.gnt), 32'b001);
      step();
      clear_all();
      chk_wr("single", 5'd3, 32'hFFFF_FEA8, 1'b1);
      @(negedge Clk);
      #1;
      chk("single.rf3", rf[3], 32'hFFFF_FEA8);
      step();

      // Round-robin from ptr=0, all three hitting r7, one write per cycle.
      reset_dut();
      for (int i = 0; i < 3; i++) drive(i, 1'b1, 1'b1, 5'd7, rr_data[i]);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rr%0d.gnt", k), 32'(bus.gnt), 32'(1) << seq[k]);
         step();
         chk_wr($sformatf("rr%0d", k), 5'd7, rr_data[seq[k]], 1'b1);
      end
      clear_all();
      @(negedge Clk);
      #1;
      chk("rr.rf7", rf[7], rr_data[0]);
      step();

      // Burst: MULDIV 26 then 27 while ALU waits; ptr is 1 here.
      drive(2, 1'b1, 1'b0, 5'd26, 32'hC0DE_0026);
      drive(0, 1'b1, 1'b1, 5'd5,  32'hA100_0005);
      #1;
      chk("burst0.gnt", 32'(bus.gnt), 32'b100);
      step();
      chk_wr("burst0", 5'd26, 32'hC0DE_0026, 1'b1);
      chk("burst0.locked", 32'(bus.locked), 32'h1);
      drive(2, 1'b1, 1'b1, 5'd27, 32'hC0DE_0027);
      #1;
      chk("burst1.gnt", 32'(bus.gnt), 32'b100);
      step();
      chk_wr("burst1", 5'd27, 32'hC0DE_0027, 1'b1);
      chk("burst1.locked", 32'(bus.locked), 32'h0);
      drive(2, 1'b0, 1'b1, 5'd0, 32'h0);
      #1;
      chk("burst2.gnt", 32'(bus.gnt), 32'b001);
      step();
      chk_wr("burst2", 5'd5, 32'hA100_0005, 1'b1);
      chk("burst2.locked", 32'(bus.locked), 32'h0);
      clear_all();

      // Register 0 is consumed without a write; ptr is 1 here.
      drive(0, 1'b1, 1'b1, 5'd0, 32'h0000_0055);
      #1;
      chk("r0.gnt", 32'(bus.gnt), 32'b001);
      step();
      clear_all();
      chk_wr("r0", 5'd0, 32'h0000_0055, 1'b0);
      @(negedge Clk);
      #1;
      chk("r0.rf0", rf[0], 32'h0);
      step();

      // Lock on MULDIV, owner drops, then Reset mid-burst; ptr is 1 here.
      drive(2, 1'b1, 1'b0, 5'd20, 32'h0000_0020);
      #1;
      chk("lock.gnt", 32'(bus.gnt), 32'b100);
      step();
      chk_wr("lock", 5'd20, 32'h0000_0020, 1'b1);
      chk("lock.locked", 32'(bus.locked), 32'h1);
      drive(2, 1'b0, 1'b0, 5'd21, 32'h0000_0021);
      drive(0, 1'b1, 1'b1, 5'd1,  32'h0000_0001);
      drive(1, 1'b1, 1'b1, 5'd2,  32'h0000_0002);
      #1;
      chk("hold.gnt", 32'(bus.gnt), 32'b000);
      step();
      chk_wr("hold", 5'd20, 32'h0000_0020, 1'b0);
      chk("hold.locked", 32'(bus.locked), 32'h1);
      drive(0, 1'b0, 1'b1, 5'd0, 32'h0);
      drive(2, 1'b1, 1'b0, 5'd21, 32'h0000_0021);
      Reset = 1'b1;
      #1;
      chk("mrst.gnt", 32'(bus.gnt), 32'b000);
      step();
      chk("mrst.writeEN", 32'(bus.writeEN), 32'h0);
      chk("mrst.locked", 32'(bus.locked), 32'h0);
      Reset = 1'b0;
      #1;
      chk("post.gnt", 32'(bus.gnt), 32'b010);
      step();
      chk_wr("post", 5'd2, 32'h0000_0002, 1'b1);
      clear_all();

      // Idle hold after a write to r9; ptr is 2 here.
      drive(1, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
      #1;
      chk("idle.gnt", 32'(bus.gnt), 32'b010);
      step();
      clear_all();
      chk_wr("idle.w", 5'd9, 32'hDEAD_BEEF, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_wr($sformatf("idle%0d", k), 5'd9, 32'hDEAD_BEEF, 1'b0);
         chk($sformatf("idle%0d.gnt", k), 32'(bus.gnt), 32'h0);
      end
      chk("idle.rf9", rf[9], 32'hDEAD_BEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
